ll_req_arbiter: RTL and testbench
=================================

# ll_req_arbiter

Round-robin arbiter that shares the single linked-list request/response interface (`req_vld`/`intf_ready`/`resp_vld`/`resp_taken`) among `NUM_REQ` independent requesters. It sits between the requesters and the linked-list request interface. It grants one requester at a time and captures that requester's request. It issues the request downstream, routes the single response back to the granted requester only, and releases the interface once the downstream FSM has returned to idle.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `PTR_WD`, 8: position width.
- `WR_DATA_WD`, 32: data width.
- `REQ_TYPE_WD`, 4: request type encoding width.
- `RESP_TYPE_WD`, 4: response type encoding width.
- `GID_WD`, `$clog2(NUM_REQ)`: grant id width (derived, not overridable).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rqstr_req_vld` in NUM_REQ: per-requester request valid; held until `rqstr_req_ack` bit seen.
- `rqstr_req_type` in NUM_REQ*REQ_TYPE_WD: flattened request types; requester i at slice i.
- `rqstr_req_pos` in NUM_REQ*PTR_WD: flattened positions.
- `rqstr_req_data` in NUM_REQ*WR_DATA_WD: flattened data.
- `rqstr_req_ack` out NUM_REQ: one-cycle one-hot pulse; request captured.
- `rqstr_resp_vld` out NUM_REQ: one-hot response valid to granted requester.
- `rqstr_resp_type` out RESP_TYPE_WD: shared response type (passthrough).
- `rqstr_resp_data` out WR_DATA_WD: shared response data (passthrough).
- `rqstr_resp_data_vld` out 1: shared response data valid (passthrough).
- `rqstr_resp_taken` in NUM_REQ: per-requester response accept.
- `req_vld` out 1: downstream request valid.
- `req_type` out REQ_TYPE_WD: downstream request type.
- `req_pos` out PTR_WD: downstream position.
- `req_data` out WR_DATA_WD: downstream data.
- `intf_ready` in 1: downstream idle/ready.
- `resp_vld` in 1: downstream response valid.
- `resp_type` in RESP_TYPE_WD: downstream response type.
- `resp_data` in WR_DATA_WD: downstream response data.
- `resp_data_vld` in 1: downstream response data valid.
- `resp_taken` out 1: downstream response accept.
- `grant_id` out GID_WD: index of current or last grant.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, RELEASE.
- **IDLE:** if `intf_ready`=1 and any `rqstr_req_vld`, pick winner g by round-robin starting at `rr_ptr`.
  - Register g into `grant_id`.
  - Capture type/pos/data slices of g into `req_type`/`req_pos`/`req_data`.
  - Pulse `rqstr_req_ack[g]` next cycle.
  - Set `rr_ptr` <= (g+1) mod NUM_REQ.
  - Go to ISSUE.
  - If `intf_ready`=0, no grant.
- **ISSUE:** `req_vld`=1. If `intf_ready`=1, go to WAIT_RESP (`req_vld` low from next cycle); else hold ISSUE with `req_vld` and payload stable.
- **WAIT_RESP:**
  - `rqstr_resp_vld[grant_id]` = `resp_vld`; all other bits 0.
  - The shared response bus is a combinational copy of the downstream response.
  - `resp_taken` = `resp_vld` & `rqstr_resp_taken[grant_id]` (combinational).
  - On that term, go to RELEASE.
  - `rqstr_resp_taken` bits of non-granted requesters are ignored.
- **RELEASE:** when `intf_ready`=1 and `resp_vld`=0, go to IDLE. `rqstr_resp_vld` is 0 and `resp_taken` is 0 in RELEASE.
- ERROR responses are forwarded unmodified; the arbiter never inspects types.
- `rqstr_req_vld` is ignored outside IDLE; losing requesters keep waiting.

## Timing
- Reset values (asynchronous):
  - State IDLE, `rr_ptr`=0, `grant_id`=0.
  - `req_vld`=0, `req_type`=0, `req_pos`=0, `req_data`=0.
  - `rqstr_req_ack`=0, `busy`=0.
  - `rqstr_resp_vld`=0, `resp_taken`=0; passthrough outputs follow their inputs.
- Grant latency: request in cycle N (IDLE, ready) -> `rqstr_req_ack` and `req_vld` both high in cycle N+1.
- `req_vld` is high for exactly one cycle when `intf_ready` stays 1.
- Minimum arbitration turnaround: next grant no earlier than the cycle after RELEASE exits.
- Simultaneous `rqstr_req_vld` and RELEASE exit: the request is seen in IDLE the following cycle.
- Reset mid-operation: everything clears immediately; an outstanding requester receives no response and must re-request.

## Configuration
- `LL_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins, `rr_ptr` is unused and held at 0.
- Undefined (default): round-robin as above.

## Test plan
- **Single request:** requester 2 sends PUSH_TAIL, data 0xA5 -> `rqstr_req_ack`=4'b0100 and `req_vld` both in cycle N+1 with `req_data`=0xA5. Downstream OP_DONE raises `rqstr_resp_vld`=4'b0100 only; `resp_taken` pulses with `rqstr_resp_taken[2]`.
- **Round-robin fairness:** all four requesters held continuously -> grant order 0,1,2,3,0,1 and each `rqstr_req_ack` bit pulses once per round.
- **Backpressure:** `rqstr_resp_taken` low for 10 cycles -> `rqstr_resp_vld[g]` stays high, `resp_taken`=0, `busy`=1, and no new ack.
- **Downstream not ready:** `intf_ready`=0 with requesters 1 and 3 valid -> no ack. When `intf_ready` rises, requester 1 is acked next cycle.
- **Reset in WAIT_RESP:** assert `reset_n`=0 -> same-cycle `req_vld`=0, `rqstr_resp_vld`=0, `busy`=0. After release, the first grant goes to requester 0 when all are requesting.
- **`LL_ARB_FIXED_PRIO_EN` defined:** requesters 1 and 3 held continuously -> requester 1 is granted every time until it drops, then requester 3.

Source files
------------

// File: rtl/ll_req_arbiter.sv
// Purpose: round-robin arbiter sharing one linked-list request/response interface among NUM_REQ requesters.
// Latency: request seen in IDLE with intf_ready -> rqstr_req_ack and req_vld high the next cycle.
// Backpressure: response held until the granted requester takes it; req_vld and payload held while intf_ready is low.
//
// Ports:
//   clk, reset_n                  - rising-edge clock, asynchronous active-low reset
//   rqstr_req_vld/type/pos/data   - per-requester requests (flattened, requester i at slice i)
//   rqstr_req_ack                 - one-cycle one-hot capture pulse
//   rqstr_resp_vld                - one-hot response valid to the granted requester
//   rqstr_resp_type/data/data_vld - shared response bus, combinational copy of downstream
//   rqstr_resp_taken              - per-requester response accept (only the granted bit matters)
//   req_vld/type/pos/data         - downstream request
//   intf_ready                    - downstream idle/ready
//   resp_vld/type/data/data_vld   - downstream response
//   resp_taken                    - downstream response accept
//   grant_id, busy                - current/last grant index, not-idle flag
//
// Build option: define LL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, rr_ptr held at 0).

module ll_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PTR_WD       = 8,
  parameter int WR_DATA_WD   = 32,
  parameter int REQ_TYPE_WD  = 4,
  parameter int RESP_TYPE_WD = 4,
  localparam int GID_WD      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              rqstr_req_vld,
  input  logic [NUM_REQ*REQ_TYPE_WD-1:0]  rqstr_req_type,
  input  logic [NUM_REQ*PTR_WD-1:0]       rqstr_req_pos,
  input  logic [NUM_REQ*WR_DATA_WD-1:0]   rqstr_req_data,
  output logic [NUM_REQ-1:0]              rqstr_req_ack,
  output logic [NUM_REQ-1:0]              rqstr_resp_vld,
  output logic [RESP_TYPE_WD-1:0]         rqstr_resp_type,
  output logic [WR_DATA_WD-1:0]           rqstr_resp_data,
  output logic                            rqstr_resp_data_vld,
  input  logic [NUM_REQ-1:0]              rqstr_resp_taken,
  output logic                            req_vld,
  output logic [REQ_TYPE_WD-1:0]          req_type,
  output logic [PTR_WD-1:0]               req_pos,
  output logic [WR_DATA_WD-1:0]           req_data,
  input  logic                            intf_ready,
  input  logic                            resp_vld,
  input  logic [RESP_TYPE_WD-1:0]         resp_type,
  input  logic [WR_DATA_WD-1:0]           resp_data,
  input  logic                            resp_data_vld,
  output logic                            resp_taken,
  output logic [GID_WD-1:0]               grant_id,
  output logic                            busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  state_t                   state;
  logic [GID_WD-1:0]        rr_ptr;

  logic                     win_vld;
  logic [GID_WD-1:0]        win_id;
  logic [NUM_REQ-1:0]       win_oh;
  logic [NUM_REQ-1:0]       grant_oh;
  logic [REQ_TYPE_WD-1:0]   win_type;
  logic [PTR_WD-1:0]        win_pos;
  logic [WR_DATA_WD-1:0]    win_data;
  logic [GID_WD-1:0]        rr_next;
  logic                     taken_sel;

  // Winner selection. Loops run from the far end down so the last hit,
  // i.e. the one closest to the search start, is the one that sticks.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
`ifdef LL_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rqstr_req_vld[GID_WD'(i)]) begin
        win_vld = 1'b1;
        win_id  = GID_WD'(i);
      end
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (rqstr_req_vld[GID_WD'(idx)]) begin
        win_vld = 1'b1;
        win_id  = GID_WD'(idx);
      end
    end
`endif
  end

  // Payload mux and one-hot decodes use constant slices only.
  always_comb begin
    win_type = '0;
    win_pos  = '0;
    win_data = '0;
    win_oh   = '0;
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i]   = (win_id == GID_WD'(i));
      grant_oh[i] = (grant_id == GID_WD'(i));
      if (win_id == GID_WD'(i)) begin
        win_type = rqstr_req_type[i*REQ_TYPE_WD +: REQ_TYPE_WD];
        win_pos  = rqstr_req_pos[i*PTR_WD +: PTR_WD];
        win_data = rqstr_req_data[i*WR_DATA_WD +: WR_DATA_WD];
      end
    end
  end

`ifdef LL_ARB_FIXED_PRIO_EN
  assign rr_next = '0;
`else
  assign rr_next = (win_id == GID_WD'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`endif

  // Only the granted requester's accept counts; others are ignored.
  assign taken_sel = |(rqstr_resp_taken & grant_oh);

  assign rqstr_resp_vld      = (state == ST_WAIT_RESP && resp_vld) ? grant_oh : '0;
  assign resp_taken          = (state == ST_WAIT_RESP) & resp_vld & taken_sel;
  assign rqstr_resp_type     = resp_type;
  assign rqstr_resp_data     = resp_data;
  assign rqstr_resp_data_vld = resp_data_vld;
  assign busy                = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      req_vld       <= 1'b0;
      req_type      <= '0;
      req_pos       <= '0;
      req_data      <= '0;
      rqstr_req_ack <= '0;
    end else begin
      rqstr_req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (intf_ready && win_vld) begin
            grant_id      <= win_id;
            req_type      <= win_type;
            req_pos       <= win_pos;
            req_data      <= win_data;
            rqstr_req_ack <= win_oh;
            req_vld       <= 1'b1;
            rr_ptr        <= rr_next;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (intf_ready) begin
            req_vld <= 1'b0;
            state   <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (resp_taken) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold the interface until downstream is idle and the response is gone.
          if (intf_ready && !resp_vld) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ll_req_arbiter.sv
module tb_ll_req_arbiter;

  localparam int NR = 4;
  localparam logic [3:0] PUSH_TAIL = 4'h2;
  localparam logic [3:0] OP_DONE   = 4'h1;
  localparam logic [3:0] ERROR_RSP = 4'hF;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   rqstr_req_vld;
  logic [NR*4-1:0] rqstr_req_type;
  logic [NR*8-1:0] rqstr_req_pos;
  logic [NR*32-1:0] rqstr_req_data;
  logic [NR-1:0]   rqstr_req_ack;
  logic [NR-1:0]   rqstr_resp_vld;
  logic [3:0]      rqstr_resp_type;
  logic [31:0]     rqstr_resp_data;
  logic            rqstr_resp_data_vld;
  logic [NR-1:0]   rqstr_resp_taken;
  logic            req_vld;
  logic [3:0]      req_type;
  logic [7:0]      req_pos;
  logic [31:0]     req_data;
  logic            intf_ready;
  logic            resp_vld;
  logic [3:0]      resp_type;
  logic [31:0]     resp_data;
  logic            resp_data_vld;
  logic            resp_taken;
  logic [1:0]      grant_id;
  logic            busy;

  int total = 0;
  int bad   = 0;

  ll_req_arbiter #(
    .NUM_REQ(4), .PTR_WD(8), .WR_DATA_WD(32), .REQ_TYPE_WD(4), .RESP_TYPE_WD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rqstr_req_vld(rqstr_req_vld), .rqstr_req_type(rqstr_req_type),
    .rqstr_req_pos(rqstr_req_pos), .rqstr_req_data(rqstr_req_data),
    .rqstr_req_ack(rqstr_req_ack), .rqstr_resp_vld(rqstr_resp_vld),
    .rqstr_resp_type(rqstr_resp_type), .rqstr_resp_data(rqstr_resp_data),
    .rqstr_resp_data_vld(rqstr_resp_data_vld), .rqstr_resp_taken(rqstr_resp_taken),
    .req_vld(req_vld), .req_type(req_type), .req_pos(req_pos), .req_data(req_data),
    .intf_ready(intf_ready), .resp_vld(resp_vld), .resp_type(resp_type),
    .resp_data(resp_data), .resp_data_vld(resp_data_vld), .resp_taken(resp_taken),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1);
  end

  // Advance one cycle and land just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From the ack (ISSUE) cycle with intf_ready=1: complete the transaction back to IDLE.
  task automatic finish_txn();
    step();
    resp_vld = 1'b1; resp_type = OP_DONE; rqstr_resp_taken = '1;
    step();
    resp_vld = 1'b0; rqstr_resp_taken = '0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rqstr_req_vld = '0; rqstr_resp_taken = '0; intf_ready = 1'b1;
    resp_vld = 1'b0; resp_type = ERROR_RSP; resp_data = 32'h1234_5678; resp_data_vld = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rqstr_req_type[i*4 +: 4]  = 4'(i + 4);
      rqstr_req_pos[i*8 +: 8]   = 8'(8'h20 + i);
      rqstr_req_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    #1;
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL rst_req_vld got=%b exp=0", req_vld); end
    total++; if (rqstr_req_ack !== 4'b0000) begin bad++; $display("FAIL rst_ack got=%b exp=0000", rqstr_req_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    total++; if ({req_type, req_pos, req_data} !== 44'd0) begin bad++; $display("FAIL rst_payload got=%h exp=0", {req_type, req_pos, req_data}); end
    total++; if (rqstr_resp_vld !== 4'b0000 || resp_taken !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b/%b exp=0000/0", rqstr_resp_vld, resp_taken); end
    total++; if ({rqstr_resp_type, rqstr_resp_data, rqstr_resp_data_vld} !== {ERROR_RSP, 32'h1234_5678, 1'b1})
      begin bad++; $display("FAIL rst_passthru got=%h/%h/%b exp=f/12345678/1", rqstr_resp_type, rqstr_resp_data, rqstr_resp_data_vld); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    rqstr_req_type[2*4 +: 4] = PUSH_TAIL;
    rqstr_req_data[2*32 +: 32] = 32'h0000_00A5;
    rqstr_req_vld = 4'b0100;
    step();
    total++; if (rqstr_req_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", rqstr_req_ack); end
    total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL single_req_vld got=%b exp=1", req_vld); end
    total++; if (req_data !== 32'hA5 || req_type !== PUSH_TAIL || req_pos !== 8'h22)
      begin bad++; $display("FAIL single_payload got=%h/%h/%h exp=a5/2/22", req_data, req_type, req_pos); end
    total++; if (grant_id !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL single_gid got=%0d/%b exp=2/1", grant_id, busy); end
    rqstr_req_vld = '0;
    step();
    total++; if (req_vld !== 1'b0 || rqstr_req_ack !== 4'b0000) begin bad++; $display("FAIL single_one_cycle got=%b/%b exp=0/0000", req_vld, rqstr_req_ack); end
    resp_vld = 1'b1; resp_type = OP_DONE; resp_data = 32'hDEAD_BEEF; resp_data_vld = 1'b1;
    rqstr_resp_taken = 4'b1011;
    #1;
    total++; if (rqstr_resp_vld !== 4'b0100) begin bad++; $display("FAIL single_resp_vld got=%b exp=0100", rqstr_resp_vld); end
    total++; if (resp_taken !== 1'b0) begin bad++; $display("FAIL single_other_taken got=%b exp=0", resp_taken); end
    rqstr_resp_taken = 4'b0100;
    #1;
    total++; if (resp_taken !== 1'b1) begin bad++; $display("FAIL single_taken got=%b exp=1", resp_taken); end
    total++; if (rqstr_resp_type !== OP_DONE || rqstr_resp_data !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL single_resp_bus got=%h/%h exp=1/deadbeef", rqstr_resp_type, rqstr_resp_data); end
    step();
    total++; if (rqstr_resp_vld !== 4'b0000 || resp_taken !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL single_release got=%b/%b/%b exp=0000/0/1", rqstr_resp_vld, resp_taken, busy); end
    resp_vld = 1'b0; rqstr_resp_taken = '0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    rqstr_req_vld = 4'b0001;
    step();
    total++; if (rqstr_req_ack !== 4'b0001) begin bad++; $display("FAIL bp_ack got=%b exp=0001", rqstr_req_ack); end
    rqstr_req_vld = 4'b1000;
    step();
    resp_vld = 1'b1; resp_type = ERROR_RSP; rqstr_resp_taken = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if (rqstr_resp_vld !== 4'b0001 || resp_taken !== 1'b0 || busy !== 1'b1 || rqstr_req_ack !== 4'b0000)
        begin bad++; $display("FAIL bp_hold c=%0d got=%b/%b/%b/%b exp=0001/0/1/0000", c, rqstr_resp_vld, resp_taken, busy, rqstr_req_ack); end
    end
    total++; if (rqstr_resp_type !== ERROR_RSP) begin bad++; $display("FAIL bp_error_fwd got=%h exp=f", rqstr_resp_type); end
    rqstr_resp_taken = 4'b0001;
    #1;
    total++; if (resp_taken !== 1'b1) begin bad++; $display("FAIL bp_taken got=%b exp=1", resp_taken); end
    step();
    resp_vld = 1'b0; rqstr_resp_taken = '0;
    step();
    // Requester 3 was valid during the RELEASE exit; it is granted one cycle later.
    total++; if (rqstr_req_ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL bp_turnaround got=%b/%b exp=0000/0", rqstr_req_ack, busy); end
    step();
    total++; if (rqstr_req_ack !== 4'b1000 || grant_id !== 2'd3) begin bad++; $display("FAIL bp_next_grant got=%b/%0d exp=1000/3", rqstr_req_ack, grant_id); end
    rqstr_req_vld = '0;
    finish_txn();
  endtask

  task automatic test_not_ready();
    intf_ready = 1'b0;
    rqstr_req_vld = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (rqstr_req_ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL nr_no_grant c=%0d got=%b/%b exp=0000/0", c, rqstr_req_ack, busy); end
    end
    intf_ready = 1'b1;
    step();
    total++; if (rqstr_req_ack !== 4'b0010 || grant_id !== 2'd1) begin bad++; $display("FAIL nr_ack got=%b/%0d exp=0010/1", rqstr_req_ack, grant_id); end
    rqstr_req_vld = '0;
    intf_ready = 1'b0;
    step();
    total++; if (req_vld !== 1'b1 || req_data !== 32'h1000_0001) begin bad++; $display("FAIL nr_issue_hold got=%b/%h exp=1/10000001", req_vld, req_data); end
    intf_ready = 1'b1;
    finish_txn();
  endtask

  task automatic test_reset_wait();
    rqstr_req_vld = 4'b0100;
    step();
    rqstr_req_vld = '0;
    step();
    resp_vld = 1'b1; rqstr_resp_taken = '0;
    #1;
    total++; if (rqstr_resp_vld !== 4'b0100) begin bad++; $display("FAIL rw_pre got=%b exp=0100", rqstr_resp_vld); end
    reset_n = 1'b0;
    #1;
    total++; if (req_vld !== 1'b0 || rqstr_resp_vld !== 4'b0000 || busy !== 1'b0)
      begin bad++; $display("FAIL rw_clear got=%b/%b/%b exp=0/0000/0", req_vld, rqstr_resp_vld, busy); end
    resp_vld = 1'b0;
    rqstr_req_vld = 4'b1111;
    step();
    reset_n = 1'b1;
    step();
    total++; if (rqstr_req_ack !== 4'b0001 || grant_id !== 2'd0) begin bad++; $display("FAIL rw_first_grant got=%b/%0d exp=0001/0", rqstr_req_ack, grant_id); end
    rqstr_req_vld = '0;
    finish_txn();
  endtask

  // Wait (bounded) for an ack and compare it with the expected requester.
  task automatic expect_grant(input int exp, input string tag);
    logic [3:0] exp_oh;
    bit found;
    exp_oh = 4'b0001 << exp;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step();
      if (rqstr_req_ack !== 4'b0000) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL %s no ack within 8 cycles exp=%b", tag, exp_oh); end
    else if (rqstr_req_ack !== exp_oh || grant_id !== 2'(exp))
      begin bad++; $display("FAIL %s got=%b/%0d exp=%b/%0d", tag, rqstr_req_ack, grant_id, exp_oh, exp); end
    step();
    total++; if (rqstr_req_ack !== 4'b0000) begin bad++; $display("FAIL %s_pulse got=%b exp=0000", tag, rqstr_req_ack); end
    resp_vld = 1'b1; rqstr_resp_taken = '1;
    step();
    resp_vld = 1'b0; rqstr_resp_taken = '0;
    step();
  endtask

`ifdef LL_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    reset_n = 1'b0; #1; reset_n = 1'b1;
    rqstr_req_vld = 4'b1010;
    for (int t = 0; t < 3; t++) expect_grant(1, "fp_grant_r1");
    rqstr_req_vld = 4'b1000;
    expect_grant(3, "fp_grant_r3");
    rqstr_req_vld = '0;
  endtask
`else
  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    reset_n = 1'b0; #1; reset_n = 1'b1;
    rqstr_req_vld = 4'b1111;
    for (int t = 0; t < 6; t++) expect_grant(order[t], "rr_grant");
    rqstr_req_vld = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_not_ready();
    test_reset_wait();
`ifdef LL_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
